// File: rtl/bcd_digit_writer_if.sv
// rtl/bcd_digit_writer_if.sv - request and digit-write port bundle for bcd_digit_writer
interface bcd_digit_writer_if #(
  parameter int VAL_W = 27
);
  logic             start;
  logic [VAL_W-1:0] value;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             wr_en;
  logic [2:0]       wr_sel;
  logic [3:0]       wr_num;

  modport master (
    output start, value,
    input  busy, done, ovf, wr_en, wr_sel, wr_num
  );

  modport slave (
    input  start, value,
    output busy, done, ovf, wr_en, wr_sel, wr_num
  );
endinterface

// File: rtl/bcd_digit_writer.sv
// rtl/bcd_digit_writer.sv - binary to 8-digit BCD (double-dabble) with sequential digit writes
module bcd_digit_writer #(
  parameter int VAL_W = 27
) (
  input  logic                clk,
  input  logic                reset,
  bcd_digit_writer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, CONV, WRITE, DONE} state_e;

  localparam logic [4:0]  LAST_ITER = 5'(VAL_W - 1);
  localparam logic [31:0] MAX_DISP  = 32'd99_999_999;

  state_e           state_q;
  logic [VAL_W-1:0] shift_q;
  logic [31:0]      bcd_q;
  logic [4:0]       iter_q;
  logic [2:0]       idx_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic             wr_en_q;
  logic [2:0]       wr_sel_q;
  logic [3:0]       wr_num_q;

  logic [31:0]         bcd_adj;
  logic [32+VAL_W-1:0] cat_d;
  logic [31:0]         bcd_d;
  logic [VAL_W-1:0]    shift_d;
  logic [2:0]          idx_d;
  logic [3:0]          num_d;

  // One double-dabble iteration: add-3 on every nibble >= 5, then shift {bcd, shift} left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    cat_d   = {bcd_adj, shift_q} << 1;
    bcd_d   = cat_d[VAL_W +: 32];
    shift_d = cat_d[VAL_W-1:0];
    idx_d   = idx_q + 3'd1;
    num_d   = bcd_q[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_en_q  <= 1'b0;
      wr_sel_q <= '0;
      wr_num_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q <= bus.value;
            bcd_q   <= '0;
            iter_q  <= '0;
            ovf_q   <= 32'(bus.value) > MAX_DISP;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_d;
          iter_q  <= iter_q + 5'd1;
          if (iter_q == LAST_ITER) begin
            // Present digit 0 straight from the final iteration's result.
            idx_q    <= '0;
            wr_en_q  <= 1'b1;
            wr_sel_q <= '0;
            wr_num_q <= ovf_q ? 4'hF : bcd_d[3:0];
            state_q  <= WRITE;
          end
        end
        WRITE: begin
          if (idx_q == 3'd7) begin
            wr_en_q  <= 1'b0;
            wr_sel_q <= '0;
            wr_num_q <= '0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            idx_q    <= idx_d;
            wr_sel_q <= idx_d;
            wr_num_q <= ovf_q ? 4'hF : num_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign bus.wr_en  = wr_en_q;
  assign bus.wr_sel = wr_sel_q;
  assign bus.wr_num = wr_num_q;

endmodule

// File: tb/tb_bcd_digit_writer.sv
// tb/tb_bcd_digit_writer.sv - directed self-checking bench for bcd_digit_writer
module tb_bcd_digit_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_digit_writer_if #(.VAL_W(27)) bus ();
  bcd_digit_writer_if #(.VAL_W(4))  bus4 ();

  bcd_digit_writer #(.VAL_W(27)) dut  (.clk(clk), .reset(reset), .bus(bus));
  bcd_digit_writer #(.VAL_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Display digit memory as the downstream block would hold it.
  logic [3:0] mem [8];
  always @(posedge clk) if (bus.wr_en) mem[bus.wr_sel] <= bus.wr_num;

  function automatic logic [31:0] mem_word();
    return {mem[7], mem[6], mem[5], mem[4], mem[3], mem[2], mem[1], mem[0]};
  endfunction

  function automatic logic [31:0] outs27();
    return 32'({bus.busy, bus.done, bus.ovf, bus.wr_en, bus.wr_sel, bus.wr_num});
  endfunction

  function automatic logic [31:0] outs4();
    return 32'({bus4.busy, bus4.done, bus4.ovf, bus4.wr_en, bus4.wr_sel, bus4.wr_num});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start now, then walks cycles 1..37 after the accepting edge.
  task automatic run_txn(input logic [26:0] v, input logic [31:0] exp, input logic exp_ovf,
                         input bit poke, input bit hold, input string tag);
    int n_conv_wr;
    int n_done;
    n_conv_wr = 0;
    n_done    = 0;
    bus.start = 1'b1;
    bus.value = v;
    step();
    if (!hold) bus.start = 1'b0;
    if (!poke) bus.value = ~v;
    for (int cyc = 1; cyc <= 37; cyc++) begin
      if (poke) begin
        bus.start = (cyc == 10) || (cyc == 30);
        if (bus.start) bus.value = 27'd7;
      end
      if (cyc == 1) check({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
      if (cyc <= 27 && bus.wr_en) n_conv_wr++;
      if (bus.done) n_done++;
      if (cyc >= 28 && cyc <= 35)
        check($sformatf("%s_wr%0d", tag, cyc - 28),
              32'({bus.wr_en, bus.wr_sel, bus.wr_num}),
              32'({1'b1, 3'(cyc - 28), exp[4*(cyc-28) +: 4]}));
      if (cyc == 36) check({tag, "_done"}, 32'({bus.done, bus.busy, bus.wr_en}), 32'b110);
      if (cyc == 37) begin
        check({tag, "_idle"}, 32'({bus.busy, bus.done}), 32'd0);
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        check({tag, "_mem"}, mem_word(), exp);
      end
      if (cyc < 37) step();
    end
    check({tag, "_conv_quiet"}, 32'(n_conv_wr), 32'd0);
    check({tag, "_done_cnt"}, 32'(n_done), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [31:0] w;
    bus.start  = 1'b0;
    bus.value  = '0;
    bus4.start = 1'b0;
    bus4.value = '0;
    step();
    step();
    check("reset_outs", outs27(), 32'd0);
    check("reset_outs4", outs4(), 32'd0);
    reset = 1'b0;
    step();
    check("idle_outs", outs27(), 32'd0);

    run_txn(27'd12_345_678, 32'h12345678, 1'b0, 1'b0, 1'b0, "normal");
    run_txn(27'd0,          32'h00000000, 1'b0, 1'b0, 1'b0, "zero");
    run_txn(27'd99_999_999, 32'h99999999, 1'b0, 1'b0, 1'b0, "max");
    run_txn(27'd100_000_000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, "ovf");
    run_txn(27'h7FF_FFFF,   32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, "allones");

    run_txn(27'd42, 32'h00000042, 1'b0, 1'b1, 1'b0, "poke");
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.busy) cnt++;
    end
    check("poke_not_queued", 32'(cnt), 32'd0);

    // Reset mid-write: third digit already landed, fourth on the bus.
    bus.start = 1'b1;
    bus.value = 27'd123_456_789;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check("pre_reset_sel", 32'(bus.wr_sel), 32'd3);
    #2 reset = 1'b1;
    #1 check("async_reset_outs", outs27(), 32'd0);
    w = mem_word();
    check("pre_reset_mem", 32'(w[11:0]), 32'hFFF);
    step();
    step();
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.wr_en || bus.done || bus.busy) cnt++;
    end
    check("post_reset_quiet", 32'(cnt), 32'd0);
    run_txn(27'd5, 32'h00000005, 1'b0, 1'b0, 1'b0, "after_reset");

    run_txn(27'd9, 32'h00000009, 1'b0, 1'b0, 1'b1, "held1");
    run_txn(27'd9, 32'h00000009, 1'b0, 1'b0, 1'b1, "held2");
    bus.start = 1'b0;
    step();
    step();

    bus4.start = 1'b1;
    bus4.value = 4'd15;
    step();
    bus4.start = 1'b0;
    bus4.value = 4'd0;
    w = 32'h00000015;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 4) check("w4_conv", outs4(), 32'h400);
      if (cyc >= 5 && cyc <= 12)
        check($sformatf("w4_wr%0d", cyc - 5),
              32'({bus4.wr_en, bus4.wr_sel, bus4.wr_num}),
              32'({1'b1, 3'(cyc - 5), w[4*(cyc-5) +: 4]}));
      if (cyc == 13) check("w4_done", 32'({bus4.done, bus4.busy}), 32'b11);
      if (cyc == 14) check("w4_idle", outs4(), 32'd0);
      if (cyc < 14) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_digit_writer.md
# bcd_digit_writer

Upstream feeder for the 8-digit seven-segment display block. Takes a binary value and converts it to eight BCD digits with a sequential shift-add-3 (double-dabble) engine. It then emits eight single-cycle digit writes on a write/sel/num port that connects directly to the display's digit memory. Shares `clk` and `reset` with the display, so writes land in the display memory on the same edge they are presented.

## Interface
- `VAL_W`, default 27: binary input width; legal range 4..27; sets conversion length.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  reset, asynchronous, active-high; clock `clk`.
- `start`  in  1  request; sampled only in IDLE.
- `value`  in  VAL_W  unsigned binary to display; captured on the accepting edge.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse after the last digit write.
- `ovf`  out  1  registered; value exceeded 99,999,999 on last accepted request.
- `wr_en`  out  1  digit write strobe; connects to display `write`.
- `wr_sel`  out  3  digit index, 0 = least-significant/rightmost (anode[0]); connects to `sel`.
- `wr_num`  out  4  digit nibble; connects to `num`.

## Operation
- States: IDLE, CONV, WRITE, DONE.
- IDLE: `start`=1 at an edge does the following on that edge: capture `value` into the shift register, clear the 32-bit BCD register, clear the iteration counter, set `ovf` to (value > 99,999,999), and go to CONV. `start`=0 stays in IDLE.
- CONV: each edge performs one iteration.
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, shift} shifts left by 1, so the shift-register MSB enters bcd[0].
  - After VAL_W iterations, go to WRITE with digit index 0.
  - BCD carry out of bit 31 is discarded; `ovf` covers that case.
- WRITE: `wr_en`=1 and `wr_sel`=index.
  - `wr_num` = bcd[4·index +: 4], or 4'hF when `ovf`=1.
  - Index increments each edge; after index 7, go to DONE.
  - Index is a 3-bit counter with no wrap beyond 7.
- DONE: `done`=1 for one cycle, then IDLE.
- `wr_en`, `wr_sel`, `wr_num`, `busy` and `done` decode from registered state only. There is no combinational path from `start` or `value` to any output.
- Outside WRITE, `wr_en`=0, `wr_sel`=0 and `wr_num`=0.
- `start` in CONV/WRITE/DONE is ignored, not queued. Changes on `value` after capture have no effect.
- `ovf` holds its value until the next accepted `start`.
- Reset, including mid-operation, immediately forces:
  - state IDLE;
  - `busy`=0, `done`=0, `ovf`=0;
  - `wr_en`=0, `wr_sel`=0, `wr_num`=0;
  - BCD, shift and counters to 0.
  - No partial write sequence resumes after release.
- Reset values of all outputs are 0.

## Timing
- Let edge E be the IDLE edge that accepts `start`.
- `busy` rises after E and stays high for VAL_W+9 cycles (36 at default).
- CONV occupies cycles 1..VAL_W after E.
- `wr_en` is high in cycles VAL_W+1..VAL_W+8, with `wr_sel` = 0,1,…,7 in order, one digit per cycle and no gaps.
- `done` is high in cycle VAL_W+9 (`busy` still high). IDLE follows in cycle VAL_W+10.
- Earliest next acceptance is the edge ending cycle VAL_W+10. `start` held high therefore produces back-to-back transactions separated by exactly one `busy`=0 cycle.
- Each digit is written into display memory on the edge that ends its `wr_en` cycle. The full display updates 8 cycles after conversion ends.

## Test plan
- **Normal conversion:** value=12,345,678, one-cycle `start` → 28 cycles after E, writes (sel,num) = (0,8),(1,7),(2,6),(3,5),(4,4),(5,3),(6,2),(7,1) on consecutive cycles. `done` is high at cycle 36, `ovf`=0, and the display memory reads 1,2,3,4,5,6,7,8 from digit 7 down to 0.
- **Boundaries:** value=0 gives eight writes of num=0. value=99,999,999 gives eight writes of num=9 with `ovf`=0. value=100,000,000 gives `ovf`=1 and eight writes of num=F. value=2^27−1 behaves the same as 100,000,000.
- **Start while busy:** accept value=42. Pulse `start` with value=7 during CONV (cycle 10) and again during WRITE → only one transaction occurs, writes 2,4,0,0,0,0,0,0, and `done` pulses exactly once.
- **Reset mid-operation:** assert `reset` asynchronously after the third write (sel=2) → all outputs are 0 before the next edge, with no `done` and no further writes. After release, a start with value=5 converts normally: writes 5,0,0,0,0,0,0,0.
- **Held start:** `start` held high with value=9 → first `done` at cycle 36, `busy`=0 for exactly one cycle, second acceptance at the edge ending cycle 37, and identical write sequences.
- **Parameter VAL_W=4:** value=15 → writes begin 5 cycles after E with (0,5),(1,1), then six zeros. `done` at cycle 13.
